multicycle_control_unit: RTL and testbench

Multi-cycle successor to the single-cycle MIPS control unit. It holds the instruction register and sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives datapath enables and the packed `{alu_op, shamt}` bus, and stalls on a ready/valid-style memory handshake. A watchdog on memory waits and an illegal-instruction trap are added; neither exists in the single-cycle unit.

---
 rtl/multicycle_control_unit.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control unit: IR, FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory-wait watchdog and illegal-instruction trap.
module multicycle_control_unit #(
    parameter int ALUOP_W = 3,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        mem_rdata,
    input  logic               mem_ready,
    input  logic               zero,
    output logic [31:0]        ir,
    output logic [ALUOP_W+4:0] aluop_shamt,
    output logic               mem_read,
    output logic               mem_write,
    output logic               iord,
    output logic               alu_src_imm,
    output logic               reg_dst_rd,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic [2:0]         state,
    output logic               illegal,
    output logic               bus_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_r, is_addi, is_lw, is_sw, is_beq, is_j;
    logic       r_ok, legal;
    logic [2:0] r_op, op_raw;
    logic [ALUOP_W-1:0] alu_op;
    logic [4:0] shamt;
    logic       wait_cyc, timeout;

    assign opcode  = ir_q[31:26];
    assign funct   = ir_q[5:0];
    assign is_r    = (opcode == 6'b000000);
    assign is_addi = (opcode == 6'b001000);
    assign is_lw   = (opcode == 6'b100011);
    assign is_sw   = (opcode == 6'b101011);
    assign is_beq  = (opcode == 6'b000100);
    assign is_j    = (opcode == 6'b000010);

    always_comb begin
        r_op = 3'd0;
        r_ok = 1'b1;
        case (funct)
            6'b100000: r_op = 3'd1;
            6'b100010: r_op = 3'd2;
            6'b100100: r_op = 3'd3;
            6'b100101: r_op = 3'd4;
            6'b000000: r_op = 3'd5;
            6'b000010: r_op = 3'd6;
            6'b101010: r_op = 3'd7;
            default:   r_ok = 1'b0;
        endcase
    end

    always_comb begin
        op_raw = 3'd0;
        unique case (1'b1)
            is_r:                     op_raw = r_op;
            is_addi | is_lw | is_sw:  op_raw = 3'd1;
            is_beq:                   op_raw = 3'd2;
            default:                  op_raw = 3'd0;
        endcase
    end

    assign legal = (is_r & r_ok) | is_addi | is_lw | is_sw | is_beq | is_j;

    // Watchdog counts stalled memory cycles; it never wraps because
    // reaching TIMEOUT without ready leaves the waiting state.
    assign wait_cyc = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
    assign timeout  = wait_cyc && (wd_q == WD_W'(TIMEOUT));
    assign wd_d     = (wait_cyc && !timeout) ? wd_q + 1'b1 : '0;

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        illegal_d   = illegal_q;
        bus_err_d   = bus_err_q;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        alu_src_imm = 1'b0;
        reg_dst_rd  = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'd0;
        alu_op      = '0;
        shamt       = 5'd0;
        unique case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_d     = mem_rdata;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_EXEC: begin
                alu_op      = ALUOP_W'(op_raw);
                shamt       = is_r ? ir_q[10:6] : 5'd0;
                alu_src_imm = is_addi | is_lw | is_sw;
                unique case (1'b1)
                    is_beq: begin
                        pc_write = zero;
                        pc_src   = 2'd1;
                        state_d  = S_FETCH;
                    end
                    is_j: begin
                        pc_write = 1'b1;
                        pc_src   = 2'd2;
                        state_d  = S_FETCH;
                    end
                    is_lw | is_sw: state_d = S_MEM;
                    default:       state_d = S_WB;
                endcase
            end
            S_MEM: begin
                iord      = 1'b1;
                mem_read  = is_lw;
                mem_write = is_sw;
                if (mem_ready) begin
                    state_d = is_lw ? S_WB : S_FETCH;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst_rd = is_r;
                mem_to_reg = is_lw;
                state_d    = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        // Reset cycle: nothing leaves the block, even mid-instruction.
        if (rst) begin
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            iord        = 1'b0;
            alu_src_imm = 1'b0;
            reg_dst_rd  = 1'b0;
            mem_to_reg  = 1'b0;
            reg_write   = 1'b0;
            pc_write    = 1'b0;
            pc_src      = 2'd0;
            alu_op      = '0;
            shamt       = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ir_q      <= 32'd0;
            wd_q      <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            wd_q      <= wd_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign ir          = ir_q;
    assign aluop_shamt = {alu_op, shamt};
    assign state       = state_q;
    assign illegal     = illegal_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: expected per-cycle control
// vectors are queued as stimulus is applied and popped at each negedge.
module tb_multicycle_control_unit;

    localparam int AW = 3;
    localparam int TO = 15;

    localparam logic [7:0] RD   = 8'h80;
    localparam logic [7:0] WR   = 8'h40;
    localparam logic [7:0] IORD = 8'h20;
    localparam logic [7:0] IMM  = 8'h10;
    localparam logic [7:0] RDST = 8'h08;
    localparam logic [7:0] M2R  = 8'h04;
    localparam logic [7:0] RW   = 8'h02;
    localparam logic [7:0] PW   = 8'h01;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   mem_rdata = 32'd0;
    logic          mem_ready = 1'b0;
    logic          zero = 1'b0;
    logic [31:0]   ir;
    logic [AW+4:0] aluop_shamt;
    logic          mem_read, mem_write, iord, alu_src_imm;
    logic          reg_dst_rd, mem_to_reg, reg_write, pc_write;
    logic [1:0]    pc_src;
    logic [2:0]    state;
    logic          illegal, bus_err;

    multicycle_control_unit #(.ALUOP_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .zero(zero), .ir(ir),
        .aluop_shamt(aluop_shamt), .mem_read(mem_read),
        .mem_write(mem_write), .iord(iord),
        .alu_src_imm(alu_src_imm), .reg_dst_rd(reg_dst_rd),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .pc_write(pc_write), .pc_src(pc_src), .state(state),
        .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic m_ill = 1'b0;
    logic m_be  = 1'b0;
    logic [22:0] exp_q[$];
    logic [22:0] obsv;

    assign obsv = {state, illegal, bus_err, mem_read, mem_write, iord,
                   alu_src_imm, reg_dst_rd, mem_to_reg, reg_write,
                   pc_write, pc_src, aluop_shamt};

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [22:0] ev(input int st, input logic [7:0] en,
                                       input int ps, input int aop,
                                       input int sh);
        return {3'(st), m_ill, m_be, en, 2'(ps), 3'(aop), 5'(sh)};
    endfunction

    task automatic step(input string tag, input logic rdy,
                        input logic [31:0] rd, input logic z,
                        input logic [22:0] e);
        mem_ready = rdy;
        mem_rdata = rd;
        zero = z;
        exp_q.push_back(e);
        @(negedge clk);
        check(tag, {41'd0, obsv}, {41'd0, exp_q.pop_front()});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        mem_ready = 1'b1;
        zero = 1'b1;
        mem_rdata = $urandom;
        @(negedge clk);
        check({tag, "_rst_en"}, {41'd0, obsv[17:0]}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ill = 1'b0;
        m_be = 1'b0;
        check({tag, "_rst_ir"}, {32'd0, ir}, 64'd0);
        check({tag, "_rst_flags"}, {62'd0, illegal, bus_err}, 64'd0);
    endtask

    task automatic run_instr(input string tag, input logic [31:0] instr,
                             input int fw, input int mw, input logic z);
        logic [5:0] op, fn;
        int aop, sh, ps;
        logic legal, r, lw, sw, beq, j, imm, pw;
        logic [7:0] en;
        op = instr[31:26];
        fn = instr[5:0];
        r = (op == 6'h00);
        lw = (op == 6'h23);
        sw = (op == 6'h2B);
        beq = (op == 6'h04);
        j = (op == 6'h02);
        imm = lw | sw | (op == 6'h08);
        legal = imm | beq | j;
        aop = 0;
        sh = 0;
        if (imm) aop = 1;
        if (beq) aop = 2;
        if (r) begin
            sh = int'(instr[10:6]);
            legal = 1'b1;
            case (fn)
                6'h20: aop = 1;
                6'h22: aop = 2;
                6'h24: aop = 3;
                6'h25: aop = 4;
                6'h00: aop = 5;
                6'h02: aop = 6;
                6'h2A: aop = 7;
                default: legal = 1'b0;
            endcase
        end
        for (int i = 0; i < fw; i++)
            step({tag, "_fwait"}, 1'b0, $urandom, 1'b0, ev(0, RD, 0, 0, 0));
        step({tag, "_fetch"}, 1'b1, instr, 1'b0, ev(0, RD | PW, 0, 0, 0));
        check({tag, "_ir"}, {32'd0, ir}, {32'd0, instr});
        step({tag, "_dec"}, 1'($urandom), $urandom, 1'b0, ev(1, 8'h00, 0, 0, 0));
        if (!legal) begin
            m_ill = 1'b1;
            for (int i = 0; i < 3; i++)
                step({tag, "_trap"}, 1'b1, $urandom, 1'b1, ev(7, 8'h00, 0, 0, 0));
            return;
        end
        pw = j | (beq & z);
        ps = beq ? 1 : (j ? 2 : 0);
        en = (imm ? IMM : 8'h00) | (pw ? PW : 8'h00);
        step({tag, "_exec"}, 1'($urandom), $urandom, z, ev(2, en, ps, aop, r ? sh : 0));
        if (lw | sw) begin
            en = IORD | (lw ? RD : WR);
            for (int i = 0; i < mw; i++)
                step({tag, "_mwait"}, 1'b0, $urandom, 1'b0, ev(3, en, 0, 0, 0));
            step({tag, "_mem"}, 1'b1, $urandom, 1'b0, ev(3, en, 0, 0, 0));
        end
        if (!(sw | beq | j)) begin
            en = RW | (r ? RDST : 8'h00) | (lw ? M2R : 8'h00);
            step({tag, "_wb"}, 1'($urandom), $urandom, 1'b0, ev(4, en, 0, 0, 0));
        end
    endtask

    logic [31:0] rtab[6] = '{32'h012A4022, 32'h012A4024, 32'h012A4025,
                             32'h00094102, 32'h012A402A, 32'h000A5140};

    initial begin
        do_reset("init");
        run_instr("add", 32'h012A4020, 0, 0, 1'b0);
        run_instr("sll", 32'h00094100, 0, 0, 1'b0);
        foreach (rtab[i])
            run_instr($sformatf("rtype%0d", i), rtab[i], 0, 0, 1'b0);
        run_instr("addi", 32'h21280005, 0, 0, 1'b0);
        run_instr("lw", 32'h8D280004, 0, 3, 1'b0);
        run_instr("sw", 32'hAD280008, 1, 0, 1'b0);
        run_instr("lw0", 32'h8D280004, 2, 0, 1'b1);
        run_instr("beq_t", 32'h1109000A, 0, 0, 1'b1);
        run_instr("beq_f", 32'h1109000A, 0, 0, 1'b0);
        run_instr("j", 32'h08000010, 0, 0, 1'b0);
        run_instr("ill_op", 32'hFC000000, 0, 0, 1'b0);
        do_reset("ill_op");
        run_instr("ill_fn", 32'h01200008, 0, 0, 1'b0);
        do_reset("ill_fn");
        // Abandon a taken branch in EXEC by resetting there.
        step("mid_fetch", 1'b1, 32'h1109000A, 1'b0, ev(0, RD | PW, 0, 0, 0));
        step("mid_dec", 1'b0, 32'd0, 1'b0, ev(1, 8'h00, 0, 0, 0));
        do_reset("mid");
        for (int i = 0; i < TO; i++)
            step("to_wait", 1'b0, $urandom, 1'b0, ev(0, RD, 0, 0, 0));
        step("to_last", 1'b0, $urandom, 1'b0, ev(0, RD, 0, 0, 0));
        m_be = 1'b1;
        for (int i = 0; i < 3; i++)
            step("to_trap", 1'b1, $urandom, 1'b1, ev(7, 8'h00, 0, 0, 0));
        do_reset("to");
        run_instr("to_edge", 32'h012A4020, TO, 0, 1'b0);
        run_instr("mto_edge", 32'hAD280008, 0, TO, 1'b0);
        run_instr("after", 32'h08000010, 0, 0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
